data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Responder end of the commit stage's data-memory interface. It owns the data array and accepts committed stores from the store buffer into a small write queue, then drains them into a single-ported synchronous array. It serves execute-stage loads with 1-cycle latency and forwards from the youngest matching queued store. It arbitrates the single array port between load reads and store drains, with starvation protection so stores always retire.

## Interface
Parameters:
- WORD_SIZE_P, 16, data and address width of the ports.
- ADDR_WIDTH_P, 10, array index width; array depth is 2^ADDR_WIDTH_P words; port addresses are truncated to the low ADDR_WIDTH_P bits.
- WQ_DEPTH_P, 4, write-queue entries (power of 2, ≥2).
- STARVE_P, 8, max cycles a non-empty queue waits before a forced drain.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  reset; asynchronous, active-low.
- w_v_i  in  1  store-buffer write valid.
- w_addr_i  in  WORD_SIZE_P  write address.
- w_data_i  in  WORD_SIZE_P  write data.
- w_ready_o  out  1  queue can accept; `= (count != WQ_DEPTH_P)`; state-only.
- r_v_i  in  1  load read valid (may be held high permanently).
- r_addr_i  in  WORD_SIZE_P  read address.
- r_ready_o  out  1  read accepted this cycle; `= !drain_forced`; state-only, never depends on r_v_i.
- r_valid_o  out  1  registered; read data valid.
- r_data_o  out  WORD_SIZE_P  registered read data; holds its last value when r_valid_o=0.
- wq_count_o  out  $clog2(WQ_DEPTH_P+1)  queued store count.
- wq_empty_o  out  1  `count == 0`.

## Operation
- **Write queue:** circular FIFO with head/tail pointers and count. Enqueue when w_v_i && w_ready_o. Entries are in commit order.
- **Array:** single port; each cycle it does one read, one drain write, or nothing.
- **Arbitration, evaluated in order:**
  - drain_forced = (count == WQ_DEPTH_P) || (starve_cnt == STARVE_P). Drain the head and pop.
  - Otherwise, if r_v_i, accept the read.
  - Otherwise, if count != 0, drain the head (opportunistic).
- **Starvation counter:** increments, saturating, each cycle count != 0 and no drain occurs. Clears on any drain or when count == 0.
- **Forwarding:** on an accepted read, compare the truncated r_addr_i against all valid entries. The youngest match wins; its data is registered with a hit flag. Otherwise the array read result is used.
- **Same-cycle effects:**
  - A same-cycle enqueue is invisible to that cycle's read.
  - Enqueue and pop in the same cycle leave count unchanged.
  - When full, a drain occurs but w_ready_o is still 0 that cycle. There is no combinational pass-through.
- **Reset** (any time, including mid-drain):
  - Queue cleared: pointers, count and starve_cnt = 0. Pending stores are discarded.
  - r_valid_o=0, r_data_o=0. Array contents are not reset.
  - Outputs after reset: w_ready_o=1, r_ready_o=1, wq_empty_o=1, wq_count_o=0.

## Timing
- **Read latency:** accept at edge t → r_valid_o=1 with data during cycle t+1. r_valid_o=0 in cycles following a non-accepted or absent read.
- **Write visibility:**
  - An enqueue at edge t is forwardable to reads accepted at t+1.
  - A drain at edge t updates the array at that edge; reads accepted at t+1 or later see the array value.
- **Drain throughput:** one store per cycle when r_v_i=0. Under continuous r_v_i, one drain every STARVE_P+1 cycles or whenever the queue is full.
- **Pointer wrap:** head and tail wrap modulo WQ_DEPTH_P; count distinguishes full from empty.

## Test plan
- **Reset:** assert reset_i=0 mid-stream → w_ready_o=1, r_ready_o=1, r_valid_o=0, r_data_o=0, wq_count_o=0, wq_empty_o=1; these hold one cycle after release.
- **Forward from queue:** r_v_i=1 always; write 0x0010←0xBEEF at t; read 0x0010 at t+1 → r_valid_o=1, r_data_o=0xBEEF at t+2, wq_count_o=1.
- **Youngest match:** enqueue 0x0020←0x1111, then 0x0020←0x2222; read 0x0020 → 0x2222. After both drain (r_v_i=0 for 2 cycles), read → 0x2222 from the array.
- **Full queue:** with r_v_i=1, enqueue 4 stores on consecutive cycles → wq_count_o=4 and w_ready_o=0. The next cycle r_ready_o=0 (forced drain); the following cycle wq_count_o=3 and w_ready_o=1. Each drain value is correct in the array on later read.
- **Starvation:** with r_v_i=1 always, enqueue 1 store at cycle 0 (count=1 from cycle 1) → r_ready_o=0 only in cycle 9, and wq_empty_o=1 from cycle 10. r_valid_o=0 in cycle 10.
- **Reset mid-operation:** array 0x0030=0x0005; queue 0x0030←0xAAAA plus 2 more stores; pulse reset_i low → wq_count_o=0. A read of 0x0030 returns 0x0005.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Data-memory port bundle between the store buffer / execute stage and the responder.
// Carries the store enqueue channel, the load read channel and queue status.
// Master drives stores and loads; slave (responder) drives ready, read data and status.
interface data_mem_responder_if #(
    parameter int WORD_SIZE_P = 16,
    parameter int WQ_DEPTH_P  = 4
);
    localparam int CW = $clog2(WQ_DEPTH_P + 1);

    logic                   w_v_i;
    logic [WORD_SIZE_P-1:0] w_addr_i;
    logic [WORD_SIZE_P-1:0] w_data_i;
    logic                   w_ready_o;
    logic                   r_v_i;
    logic [WORD_SIZE_P-1:0] r_addr_i;
    logic                   r_ready_o;
    logic                   r_valid_o;
    logic [WORD_SIZE_P-1:0] r_data_o;
    logic [CW-1:0]          wq_count_o;
    logic                   wq_empty_o;

    modport master (
        output w_v_i, w_addr_i, w_data_i, r_v_i, r_addr_i,
        input  w_ready_o, r_ready_o, r_valid_o, r_data_o, wq_count_o, wq_empty_o
    );

    modport slave (
        input  w_v_i, w_addr_i, w_data_i, r_v_i, r_addr_i,
        output w_ready_o, r_ready_o, r_valid_o, r_data_o, wq_count_o, wq_empty_o
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-array owner: queues committed stores, drains them into a 1-port array, serves loads with forwarding.
// Latency: load accepted at edge t returns data in cycle t+1; stores are forwardable one cycle after enqueue.
// Backpressure: w_ready_o drops when the queue is full; r_ready_o drops on cycles a drain is forced.
// Ports: clk_i/reset_i (async active-low) plus the slave side of data_mem_responder_if (bus).
module data_mem_responder #(
    parameter int WORD_SIZE_P  = 16,
    parameter int ADDR_WIDTH_P = 10,
    parameter int WQ_DEPTH_P   = 4,
    parameter int STARVE_P     = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    data_mem_responder_if.slave   bus
);
    localparam int CW    = $clog2(WQ_DEPTH_P + 1);
    localparam int PW    = $clog2(WQ_DEPTH_P);
    localparam int SW    = $clog2(STARVE_P + 1);
    localparam int DEPTH = 1 << ADDR_WIDTH_P;

    localparam logic [CW-1:0] FULL_C   = CW'(WQ_DEPTH_P);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_P);

    typedef logic [ADDR_WIDTH_P-1:0] idx_t;
    typedef logic [WORD_SIZE_P-1:0]  word_t;

    // Storage without reset: array contents and queue payloads survive reset.
    word_t mem    [DEPTH];
    idx_t  q_addr [WQ_DEPTH_P];
    word_t q_data [WQ_DEPTH_P];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [SW-1:0] starve_cnt;

    logic  drain_forced;
    logic  do_drain;
    logic  rd_acc;
    logic  push;
    idx_t  r_idx;
    idx_t  w_idx;

    logic          fwd_hit_d;
    word_t         fwd_data_d;
    logic [PW-1:0] scan_ptr;

    logic  r_valid;
    logic  fwd_hit;
    word_t fwd_data;
    word_t arr_data;
    word_t held_data;
    word_t rd_live;

    logic  unused_addr_bits;

    assign r_idx = bus.r_addr_i[ADDR_WIDTH_P-1:0];
    assign w_idx = bus.w_addr_i[ADDR_WIDTH_P-1:0];
    assign unused_addr_bits = ^{bus.r_addr_i[WORD_SIZE_P-1:ADDR_WIDTH_P],
                                bus.w_addr_i[WORD_SIZE_P-1:ADDR_WIDTH_P]};

    // Port arbitration: forced drain beats loads, loads beat opportunistic drains.
    // starve_cnt is held at 0 while empty, so a forced drain always has an entry.
    assign drain_forced = (count == FULL_C) || (starve_cnt == STARVE_C);
    assign rd_acc       = bus.r_v_i && !drain_forced;
    assign do_drain     = (count != '0) && (drain_forced || !bus.r_v_i);
    assign push         = bus.w_v_i && (count != FULL_C);

    // Walk the queue oldest to youngest so the last match (youngest) wins.
    always_comb begin
        fwd_hit_d  = 1'b0;
        fwd_data_d = '0;
        scan_ptr   = '0;
        for (int i = 0; i < WQ_DEPTH_P; i++) begin
            scan_ptr = head + PW'(i);
            if ((CW'(i) < count) && (q_addr[scan_ptr] == r_idx)) begin
                fwd_hit_d  = 1'b1;
                fwd_data_d = q_data[scan_ptr];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            starve_cnt <= '0;
            r_valid    <= 1'b0;
            fwd_hit    <= 1'b0;
            fwd_data   <= '0;
            held_data  <= '0;
        end else begin
            if (push)     tail <= tail + PW'(1);
            if (do_drain) head <= head + PW'(1);
            count <= count + CW'(push) - CW'(do_drain);

            if ((count == '0) || do_drain)
                starve_cnt <= '0;
            else if (starve_cnt != STARVE_C)
                starve_cnt <= starve_cnt + SW'(1);

            r_valid <= rd_acc;
            if (rd_acc) begin
                fwd_hit  <= fwd_hit_d;
                fwd_data <= fwd_data_d;
            end
            // Capture the presented value so r_data_o holds across idle cycles.
            if (r_valid) held_data <= rd_live;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            q_addr[tail] <= w_idx;
            q_data[tail] <= bus.w_data_i;
        end
    end

    // Single array port: one drain write or one read per cycle, never both.
    always_ff @(posedge clk_i) begin
        if (do_drain)
            mem[q_addr[head]] <= q_data[head];
        else if (rd_acc)
            arr_data <= mem[r_idx];
    end

    assign rd_live = fwd_hit ? fwd_data : arr_data;

    assign bus.w_ready_o  = (count != FULL_C);
    assign bus.r_ready_o  = !drain_forced;
    assign bus.r_valid_o  = r_valid;
    assign bus.r_data_o   = r_valid ? rd_live : held_data;
    assign bus.wq_count_o = count;
    assign bus.wq_empty_o = (count == '0);
endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
    logic clk_i = 1'b0;
    logic reset_i;

    always #5 clk_i = ~clk_i;

    data_mem_responder_if #(.WORD_SIZE_P(16), .WQ_DEPTH_P(4)) bus ();

    data_mem_responder #(
        .WORD_SIZE_P (16),
        .ADDR_WIDTH_P(10),
        .WQ_DEPTH_P  (4),
        .STARVE_P    (8)
    ) dut (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic wv, input logic [15:0] wa, input logic [15:0] wd,
                         input logic rv, input logic [15:0] ra);
        bus.w_v_i    = wv;
        bus.w_addr_i = wa;
        bus.w_data_i = wd;
        bus.r_v_i    = rv;
        bus.r_addr_i = ra;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, ".w_ready"}, 32'(bus.w_ready_o), 32'd1);
        check_eq({tag, ".r_ready"}, 32'(bus.r_ready_o), 32'd1);
        check_eq({tag, ".r_valid"}, 32'(bus.r_valid_o), 32'd0);
        check_eq({tag, ".r_data"},  32'(bus.r_data_o),  32'd0);
        check_eq({tag, ".count"},   32'(bus.wq_count_o), 32'd0);
        check_eq({tag, ".empty"},   32'(bus.wq_empty_o), 32'd1);
    endtask

    initial begin
        reset_i = 1'b0;
        drive(0, 16'h0, 16'h0, 0, 16'h0);
        step();
        step();
        check_idle("por");
        reset_i = 1'b1;
        step();
        check_idle("por_release");

        // Forward from queue: store at t, load at t+1, data at t+2.
        drive(1, 16'h0010, 16'hBEEF, 1, 16'h03FF);
        step();
        drive(0, 16'h0, 16'h0, 1, 16'h0010);
        check_eq("fwd.count_t1", 32'(bus.wq_count_o), 32'd1);
        step();
        check_eq("fwd.valid", 32'(bus.r_valid_o), 32'd1);
        check_eq("fwd.data",  32'(bus.r_data_o),  32'hBEEF);
        check_eq("fwd.count_t2", 32'(bus.wq_count_o), 32'd1);
        drive(0, 16'h0, 16'h0, 0, 16'h0);
        step();
        check_eq("fwd.drained", 32'(bus.wq_count_o), 32'd0);

        // Youngest match wins, then the same value comes back from the array.
        drive(1, 16'h0020, 16'h1111, 1, 16'h03FF);
        step();
        drive(1, 16'h0020, 16'h2222, 1, 16'h03FF);
        step();
        drive(0, 16'h0, 16'h0, 1, 16'h0020);
        check_eq("young.count", 32'(bus.wq_count_o), 32'd2);
        step();
        check_eq("young.valid", 32'(bus.r_valid_o), 32'd1);
        check_eq("young.fwd_data", 32'(bus.r_data_o), 32'h2222);
        drive(0, 16'h0, 16'h0, 0, 16'h0);
        step();
        step();
        check_eq("young.empty", 32'(bus.wq_empty_o), 32'd1);
        drive(0, 16'h0, 16'h0, 1, 16'h0020);
        step();
        check_eq("young.arr_data", 32'(bus.r_data_o), 32'h2222);
        drive(0, 16'h0, 16'h0, 0, 16'h0);
        step();
        check_eq("young.idle_valid", 32'(bus.r_valid_o), 32'd0);
        check_eq("young.hold_data", 32'(bus.r_data_o), 32'h2222);

        // Full queue under continuous loads forces a drain.
        for (int i = 0; i < 4; i++) begin
            drive(1, 16'h0040 + 16'(i), 16'hC000 + 16'(i), 1, 16'h03FF);
            step();
        end
        drive(0, 16'h0, 16'h0, 1, 16'h03FF);
        check_eq("full.count", 32'(bus.wq_count_o), 32'd4);
        check_eq("full.w_ready", 32'(bus.w_ready_o), 32'd0);
        check_eq("full.r_ready", 32'(bus.r_ready_o), 32'd0);
        step();
        check_eq("full.count_after", 32'(bus.wq_count_o), 32'd3);
        check_eq("full.w_ready_after", 32'(bus.w_ready_o), 32'd1);
        check_eq("full.r_ready_after", 32'(bus.r_ready_o), 32'd1);
        drive(0, 16'h0, 16'h0, 0, 16'h0);
        step();
        step();
        step();
        check_eq("full.empty", 32'(bus.wq_empty_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            drive(0, 16'h0, 16'h0, 1, 16'h0040 + 16'(i));
            step();
            check_eq($sformatf("full.rd%0d", i), 32'(bus.r_data_o), 32'hC000 + 32'(i));
        end

        // Starvation: one store, loads every cycle; forced drain in cycle 9.
        drive(1, 16'h0050, 16'h5555, 1, 16'h03FF);
        step();
        drive(0, 16'h0, 16'h0, 1, 16'h03FF);
        for (int c = 1; c <= 10; c++) begin
            check_eq($sformatf("starve.r_ready_c%0d", c), 32'(bus.r_ready_o), (c == 9) ? 32'd0 : 32'd1);
            check_eq($sformatf("starve.empty_c%0d", c), 32'(bus.wq_empty_o), (c == 10) ? 32'd1 : 32'd0);
            if (c == 10)
                check_eq("starve.r_valid_c10", 32'(bus.r_valid_o), 32'd0);
            else
                step();
        end
        drive(0, 16'h0, 16'h0, 1, 16'h0050);
        step();
        check_eq("starve.arr_data", 32'(bus.r_data_o), 32'h5555);

        // Reset mid-operation discards queued stores; array keeps its contents.
        drive(1, 16'h0030, 16'h0005, 0, 16'h0);
        step();
        drive(0, 16'h0, 16'h0, 0, 16'h0);
        step();
        step();
        check_eq("rst.pre_empty", 32'(bus.wq_empty_o), 32'd1);
        drive(1, 16'h0030, 16'hAAAA, 1, 16'h0030);
        step();
        check_eq("rst.same_cycle_invisible", 32'(bus.r_data_o), 32'h0005);
        drive(1, 16'h0031, 16'hBBBB, 1, 16'h0030);
        step();
        check_eq("rst.fwd1", 32'(bus.r_data_o), 32'hAAAA);
        drive(1, 16'h0032, 16'hCCCC, 1, 16'h0030);
        step();
        check_eq("rst.fwd2", 32'(bus.r_data_o), 32'hAAAA);
        drive(0, 16'h0, 16'h0, 1, 16'h03FF);
        check_eq("rst.pre_count", 32'(bus.wq_count_o), 32'd3);
        check_eq("rst.pre_valid", 32'(bus.r_valid_o), 32'd1);
        #2;
        reset_i = 1'b0;
        #1;
        check_idle("rst.async");
        drive(0, 16'h0, 16'h0, 0, 16'h0);
        step();
        check_idle("rst.held_low");
        reset_i = 1'b1;
        step();
        check_idle("rst.release");
        drive(0, 16'h0, 16'h0, 1, 16'h0030);
        step();
        check_eq("rst.arr_valid", 32'(bus.r_valid_o), 32'd1);
        check_eq("rst.arr_data", 32'(bus.r_data_o), 32'h0005);
        drive(0, 16'h0, 16'h0, 0, 16'h0);
        step();
        check_eq("rst.count_stays", 32'(bus.wq_count_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
